// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned MUL/DIV unit that stalls the pipeline while busy; `MULDIV_EARLY_EXIT_EN enables zero-operand early exit
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd4;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, low_q, opd_q, hi_q, lo_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_trial, mul_acc_d, mul_low_d, div_acc_d, div_low_d;
  logic             div_ok, last, acc_mul, acc_div, early;
  // one shift-add / restoring-subtract step on the shared acc:low pair, plus accept decode
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opd_q} : '0);
    mul_acc_d = mul_sum[WIDTH:1];
    mul_low_d = {mul_sum[0], low_q[WIDTH-1:1]};
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, opd_q};
    div_trial = div_shift[WIDTH-1:0] - opd_q;
    div_acc_d = div_ok ? div_trial : div_shift[WIDTH-1:0];
    div_low_d = {low_q[WIDTH-2:0], div_ok};
    last      = cnt_q == CW'(WIDTH - 1);
    acc_mul   = start && alu_ctrl == OP_MUL;
    acc_div   = start && alu_ctrl == OP_DIV;
`ifdef MULDIV_EARLY_EXIT_EN
    early     = (acc_mul && (src_a == '0 || src_b == '0)) || (acc_div && src_b == '0);
`else
    early     = 1'b0;
`endif
  end
  // sequencer FSM: latches operands on accept, iterates WIDTH times, publishes hi/lo with a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_mul || acc_div) begin
            cnt_q <= '0;
            acc_q <= '0;
            opd_q <= acc_mul ? src_a : src_b;
            low_q <= acc_mul ? src_b : src_a;
            dz_q  <= 1'b0;
            if (early) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hi_q    <= acc_mul ? '0 : src_a;
              lo_q    <= acc_mul ? '0 : '1;
              dz_q    <= acc_div;
            end else begin
              state_q <= acc_mul ? MUL : DIV;
              busy_q  <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q <= mul_acc_d;
          low_q <= mul_low_d;
          cnt_q <= last ? cnt_q : cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= mul_acc_d;
            lo_q    <= mul_low_d;
          end
        end
        DIV: begin
          acc_q <= div_acc_d;
          low_q <= div_low_d;
          cnt_q <= last ? cnt_q : cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= div_acc_d;
            lo_q    <= div_low_d;
            dz_q    <= opd_q == '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy     = busy_q;
  assign stall    = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
endmodule
